seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the 7-segment digit driver.
- Watches the multiplexed 4-digit display bus (abcdefg pattern, dp, per-digit enables) and reconstructs the numeric value of each digit position.
- A stability filter rejects ghosting/transition patterns; non-digit patterns are flagged.
- Used for self-check/loopback of the display path and in benches as a display monitor.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (dig_en width).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern, bit6=a … bit0=g, active-high.
- dp_in  in  1  decimal point, active-high.
- dig_en  in  NUM_DIGITS  digit enables, active-high, expected one-hot.
- digits_out  out  4*NUM_DIGITS  captured values, nibble k = digit k (BCD, or hex with option).
- dp_out  out  NUM_DIGITS  captured dp per digit.
- digit_valid  out  NUM_DIGITS  bit k set once digit k holds a decoded value.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err_invalid  out  1  sticky: a stable pattern failed to decode.

Behaviour:
- Reset (async, immediate):
  - digits_out=0, dp_out=0, digit_valid=0, frame_done=0, err_invalid=0.
  - Stability counter=0, captured mask=0, previous-sample register=0.
- Input sample = {dig_en, seg_in, dp_in}, registered each edge into prev.
- Stability counter:
  - Increments (saturating at STABLE_CYCLES) while the sample equals prev.
  - Reloads to 1 when the sample differs from prev.
  - Forced to 0 while dig_en is not one-hot (zero or multiple bits). Such a sample is a blanking interval: no capture, no error.
- Capture event: fires on the single edge at which the counter reaches STABLE_CYCLES with a one-hot dig_en. Holding the same sample longer produces no further capture.
  - With STABLE_CYCLES=4 and input constant from edge n, capture occurs at edge n+3. Outputs are visible after that edge.
- On capture for digit k:
  - Recognised pattern: nibble k ← value, dp_out[k] ← dp_in, digit_valid[k] ← 1.
  - Unrecognised pattern: nibble k and dp_out[k] unchanged, digit_valid[k] ← 0, err_invalid ← 1.
- Recognised patterns (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - All-off 0000000 is invalid.
- Frame tracking:
  - Each capture (valid or invalid) sets captured-mask bit k.
  - On the edge where the mask becomes all-ones, frame_done=1 for one cycle and the mask clears.
  - A capture in that same cycle starts the new mask.
- err_invalid clears only on rst.
- Reset mid-capture discards the partial count. No capture may occur on the first edge after reset release.

Optional Feature:
- Macro: SEG7_SCAN_HEX_EN.
- Defined: hex patterns also decode, digit_valid=1 for these:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Undefined: those six patterns are invalid and raise err_invalid.

Decomposition:
- Package seg7_pkg holds:
  - Pattern constants SEG_0..SEG_9 and SEG_A..SEG_F.
  - NUM_DIGITS_DEFAULT.
  - A typedef for the 7-bit pattern.
  - A typedef for the 4-bit digit value.
- Natural sub-module seg7_pattern_decode: combinational, pattern → {value[3:0], ok}. The hex macro lives there.
- Top level: sampling, stability counter, capture, frame logic.

Test Plan:
- Reset, then dig_en=0001, seg_in=1111001 held 4 cycles → after 4th edge: nibble0=3, digit_valid=0001, err_invalid=0.
- Scan digits 0..3 with patterns for 1,2,3,4, each held 5 cycles → digits_out=16'h4321, frame_done pulses exactly once, 1 cycle wide.
- Hold 1011011 for only 3 cycles on digit 2, then change → no capture, digit_valid[2] unchanged.
- dig_en=0011 with a valid pattern held 10 cycles → no capture, no error; returning to 0010 then holding 4 cycles captures digit 1.
- Digit 1 held at 1110111 for 4 cycles:
  - Macro off → err_invalid=1, digit_valid[1]=0.
  - Macro on → nibble1=A, digit_valid[1]=1.
- Assert rst asynchronously mid-hold on digit 3 (count=2) → all outputs 0 immediately; a fresh 4-cycle hold is needed after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants and shared types for the 7-segment scan decoder.
package seg7_pkg;

    localparam int NUM_DIGITS_DEFAULT = 4;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] digit_t;

    // abcdefg, bit6 = a
    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b0011111;
    localparam seg_t SEG_C = 7'b1001110;
    localparam seg_t SEG_D = 7'b0111101;
    localparam seg_t SEG_E = 7'b1001111;
    localparam seg_t SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: segment pattern to digit value; SEG7_SCAN_HEX_EN also accepts A..F.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       ok
);

    always_comb begin
        ok    = 1'b1;
        value = '0;
        case (seg)
            SEG_0: value = 4'h0;
            SEG_1: value = 4'h1;
            SEG_2: value = 4'h2;
            SEG_3: value = 4'h3;
            SEG_4: value = 4'h4;
            SEG_5: value = 4'h5;
            SEG_6: value = 4'h6;
            SEG_7: value = 4'h7;
            SEG_8: value = 4'h8;
            SEG_9: value = 4'h9;
`ifdef SEG7_SCAN_HEX_EN
            SEG_A: value = 4'hA;
            SEG_B: value = 4'hB;
            SEG_C: value = 4'hC;
            SEG_D: value = 4'hD;
            SEG_E: value = 4'hE;
            SEG_F: value = 4'hF;
`endif
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds per-digit values from a multiplexed 7-segment bus.
// Hex decoding is enabled by SEG7_SCAN_HEX_EN (inside seg7_pattern_decode).
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = NUM_DIGITS_DEFAULT,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic                    dp_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_invalid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NUM_DIGITS + 8;

    logic [SW-1:0]         sample, prev;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] mask, mask_next;
    logic                  one_hot, same, capture, ok;
    digit_t                value;

    assign sample    = {dig_en, seg_in, dp_in};
    assign one_hot   = dig_en != '0 && (dig_en & (dig_en - NUM_DIGITS'(1))) == '0;
    assign same      = sample == prev;
    // capture only on the edge that takes the count up to STABLE_CYCLES
    assign capture   = one_hot && same && cnt == CW'(STABLE_CYCLES - 1);
    assign mask_next = mask | (capture ? dig_en : '0);

    seg7_pattern_decode u_dec (
        .seg   (seg_in),
        .value (value),
        .ok    (ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev        <= '0;
            cnt         <= '0;
            mask        <= '0;
            digits_out  <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            prev       <= sample;
            cnt        <= !one_hot ? '0 : !same ? CW'(1) : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
            frame_done <= &mask_next;
            mask       <= &mask_next ? '0 : mask_next;
            if (capture && !ok) err_invalid <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && dig_en[i]) begin
                    digit_valid[i] <= ok;
                    if (ok) begin
                        digits_out[4*i +: 4] <= value;
                        dp_out[i]            <= dp_in;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scenarios plus randomized bus traffic against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int ST = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_in = '0;
    logic            dp_in = 1'b0;
    logic [ND-1:0]   dig_en = '0;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   dp_out, digit_valid;
    logic            frame_done, err_invalid;

    int checks = 0;
    int errors = 0;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`ifdef SEG7_SCAN_HEX_EN
    localparam int NVAL = 16;
`else
    localparam int NVAL = 10;
`endif

    // model: captures happen when a one-hot sample has been seen exactly ST times in a row
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_dp, m_valid, m_mask;
    logic          m_frame, m_err;
    logic [ND+7:0] m_last;
    int            m_run;

    function automatic int ref_decode(input logic [6:0] s);
        for (int i = 0; i < NVAL; i++) if (pat[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [4*ND-1:0] m_pack();
        logic [4*ND-1:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = '0;
        m_dp = '0; m_valid = '0; m_mask = '0; m_frame = 0; m_err = 0; m_last = '0; m_run = 0;
    endtask

    task automatic model_edge();
        logic [ND+7:0] s;
        int k, d;
        s = {dig_en, seg_in, dp_in};
        m_frame = 0;
        if ($countones(dig_en) != 1) m_run = 0;
        else if (s == m_last) m_run++;
        else m_run = 1;
        m_last = s;
        if (m_run == ST) begin
            k = $clog2(dig_en);
            d = ref_decode(seg_in);
            if (d >= 0) begin
                m_dig[k] = d[3:0]; m_dp[k] = dp_in; m_valid[k] = 1'b1;
            end else begin
                m_valid[k] = 1'b0; m_err = 1'b1;
            end
            m_mask[k] = 1'b1;
            if (&m_mask) begin m_frame = 1; m_mask = '0; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks += 5;
        if (digits_out !== '0) begin errors++; $display("FAIL reset_digits got=%h exp=0", digits_out); end
        if (dp_out !== '0) begin errors++; $display("FAIL reset_dp got=%b exp=0", dp_out); end
        if (digit_valid !== '0) begin errors++; $display("FAIL reset_valid got=%b exp=0", digit_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame_done); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_invalid); end
        #4 rst = 1'b0;
    endtask

    task automatic test_single();
        dig_en = 4'b0001; seg_in = 7'b1111001; dp_in = 1'b0;
        repeat (3) tick();
        checks++;
        if (digit_valid !== 4'b0000) begin errors++; $display("FAIL single_early got=%b exp=0000", digit_valid); end
        tick();
        checks += 3;
        if (digits_out[3:0] !== 4'h3) begin errors++; $display("FAIL single_nibble got=%h exp=3", digits_out[3:0]); end
        if (digit_valid !== 4'b0001) begin errors++; $display("FAIL single_valid got=%b exp=0001", digit_valid); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err_invalid); end
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int d = 0; d < 4; d++) begin
            dig_en = 4'(1 << d); seg_in = pat[d+1];
            repeat (5) begin
                tick();
                if (frame_done === 1'b1) pulses++;
                checks++;
                if (frame_done !== m_frame) begin errors++; $display("FAIL scan_frame got=%b exp=%b", frame_done, m_frame); end
            end
        end
        checks += 3;
        if (digits_out !== 16'h4321) begin errors++; $display("FAIL scan_digits got=%h exp=4321", digits_out); end
        if (digit_valid !== 4'b1111) begin errors++; $display("FAIL scan_valid got=%b exp=1111", digit_valid); end
        if (pulses != 1) begin errors++; $display("FAIL scan_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_short_hold();
        dig_en = 4'b0100; seg_in = 7'b1011011;
        repeat (3) tick();
        dig_en = 4'b0000;
        tick();
        checks += 2;
        if (digit_valid[2] !== 1'b1) begin errors++; $display("FAIL short_valid got=%b exp=1", digit_valid[2]); end
        if (digits_out[11:8] !== 4'h3) begin errors++; $display("FAIL short_nibble got=%h exp=3", digits_out[11:8]); end
    endtask

    task automatic test_blanking();
        dig_en = 4'b0011; seg_in = pat[7];
        repeat (10) tick();
        checks += 2;
        if (digits_out !== 16'h4321) begin errors++; $display("FAIL blank_digits got=%h exp=4321", digits_out); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL blank_err got=%b exp=0", err_invalid); end
        dig_en = 4'b0010;
        repeat (4) tick();
        checks += 2;
        if (digits_out[7:4] !== 4'h7) begin errors++; $display("FAIL blank_capture got=%h exp=7", digits_out[7:4]); end
        if (digit_valid !== 4'b1111) begin errors++; $display("FAIL blank_valid got=%b exp=1111", digit_valid); end
    endtask

    task automatic test_hex();
        dig_en = 4'b0010; seg_in = 7'b1110111;
        repeat (4) tick();
        checks += 3;
`ifdef SEG7_SCAN_HEX_EN
        if (digits_out[7:4] !== 4'hA) begin errors++; $display("FAIL hex_nibble got=%h exp=a", digits_out[7:4]); end
        if (digit_valid[1] !== 1'b1) begin errors++; $display("FAIL hex_valid got=%b exp=1", digit_valid[1]); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL hex_err got=%b exp=0", err_invalid); end
`else
        if (digits_out[7:4] !== 4'h7) begin errors++; $display("FAIL hex_nibble got=%h exp=7", digits_out[7:4]); end
        if (digit_valid[1] !== 1'b0) begin errors++; $display("FAIL hex_valid got=%b exp=0", digit_valid[1]); end
        if (err_invalid !== 1'b1) begin errors++; $display("FAIL hex_err got=%b exp=1", err_invalid); end
`endif
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            dig_en = r < 7 ? 4'(1 << $urandom_range(0, 3)) : r == 7 ? 4'b0000 : 4'($urandom);
            seg_in = $urandom_range(0, 3) != 0 ? pat[$urandom_range(0, 15)] : 7'($urandom);
            dp_in  = 1'($urandom);
            repeat ($urandom_range(1, 6)) begin
                tick();
                checks += 5;
                if (digits_out !== m_pack()) begin errors++; $display("FAIL rand_digits got=%h exp=%h", digits_out, m_pack()); end
                if (dp_out !== m_dp) begin errors++; $display("FAIL rand_dp got=%b exp=%b", dp_out, m_dp); end
                if (digit_valid !== m_valid) begin errors++; $display("FAIL rand_valid got=%b exp=%b", digit_valid, m_valid); end
                if (frame_done !== m_frame) begin errors++; $display("FAIL rand_frame got=%b exp=%b", frame_done, m_frame); end
                if (err_invalid !== m_err) begin errors++; $display("FAIL rand_err got=%b exp=%b", err_invalid, m_err); end
            end
        end
    endtask

    task automatic test_async_reset();
        dig_en = 4'b1000; seg_in = pat[8]; dp_in = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks += 4;
        if (digits_out !== '0) begin errors++; $display("FAIL areset_digits got=%h exp=0", digits_out); end
        if (dp_out !== '0) begin errors++; $display("FAIL areset_dp got=%b exp=0", dp_out); end
        if (digit_valid !== '0) begin errors++; $display("FAIL areset_valid got=%b exp=0", digit_valid); end
        if ({frame_done, err_invalid} !== 2'b00) begin errors++; $display("FAIL areset_flags got=%b exp=00", {frame_done, err_invalid}); end
        #1 rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (digit_valid !== 4'b0000) begin errors++; $display("FAIL areset_early got=%b exp=0000", digit_valid); end
        tick();
        checks += 3;
        if (digit_valid !== 4'b1000) begin errors++; $display("FAIL areset_valid2 got=%b exp=1000", digit_valid); end
        if (digits_out[15:12] !== 4'h8) begin errors++; $display("FAIL areset_nibble got=%h exp=8", digits_out[15:12]); end
        if (dp_out !== 4'b1000) begin errors++; $display("FAIL areset_dp2 got=%b exp=1000", dp_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_short_hold();
        test_blanking();
        test_hex();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
